// File: rtl/risc_io_bridge.sv
// Memory-mapped bridge between the 16-bit RISC processor bus, the 256x16 RAM
// and an I/O window holding a transmit FIFO, a status register and an rx holding register.
module risc_io_bridge #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          PTR_W      = 2,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_mw_en,
  output logic [15:0] cpu_rdata,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [15:0]    TXD_ADDR  = IO_BASE;
  localparam logic [15:0]    STAT_ADDR = IO_BASE + 16'd1;
  localparam logic [15:0]    RXD_ADDR  = IO_BASE + 16'd2;
  localparam logic [PTR_W:0] FULL_CNT  = FIFO_DEPTH[PTR_W:0];

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ovf;
  logic             rx_full;
  logic [15:0]      rx_hold;
  logic             mw_q;

  logic ram_sel, txd_sel, stat_sel, rxd_sel;
  logic io_wr, push, pop, push_ok;
  logic tx_empty, tx_full;

  assign ram_sel  = (cpu_addr[15:8] == 8'h00);
  assign txd_sel  = (cpu_addr == TXD_ADDR);
  assign stat_sel = (cpu_addr == STAT_ADDR);
  assign rxd_sel  = (cpu_addr == RXD_ADDR);

  assign ram_addr  = cpu_addr[7:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_mw_en & ram_sel;

  // The processor may hold mw_en for several cycles; only its rising edge acts on I/O.
  assign io_wr = cpu_mw_en & ~mw_q;

  assign tx_empty = (count == '0);
  assign tx_full  = (count == FULL_CNT);

  // Valid/ready: a word transfers on a rising clk edge where valid and ready are
  // both high; valid never depends on ready, and both only change on clock edges.
  assign tx_valid = ~tx_empty;
  assign tx_data  = mem[rd_ptr];
  assign rx_ready = ~rx_full;

  assign push    = io_wr & txd_sel;
  assign pop     = tx_valid & tx_ready;
  assign push_ok = push & (~tx_full | pop);

  always_comb begin
    cpu_rdata = 16'h0000;
    if (ram_sel)       cpu_rdata = ram_rdata;
    else if (stat_sel) cpu_rdata = {11'b0, rx_full, ovf, tx_full, tx_empty, 1'b0};
    else if (rxd_sel)  cpu_rdata = rx_hold;
  end

  // FIFO storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      rx_full <= 1'b0;
      rx_hold <= 16'h0000;
      mw_q    <= 1'b0;
    end else begin
      mw_q <= cpu_mw_en;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & tx_full & ~pop)   ovf <= 1'b1;
      else if (io_wr & stat_sel)   ovf <= 1'b0;
      if (rx_valid & rx_ready) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (io_wr & rxd_sel) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc_io_bridge.sv
// Bench for risc_io_bridge: decode table, then hand-written FIFO/rx/reset sequences
// checked against a small behavioural model whose tx queue doubles as scoreboard.
module tb_risc_io_bridge;

  localparam logic [15:0] TXD  = 16'hFF00;
  localparam logic [15:0] STAT = 16'hFF01;
  localparam logic [15:0] RXD  = 16'hFF02;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_mw_en;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_we;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  risc_io_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mw_en(cpu_mw_en),
    .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state; exp_q holds the words expected on tx_data in order.
  logic [15:0] exp_q[$];
  logic        m_ovf = 1'b0, m_rx_full = 1'b0, m_mw_q = 1'b0;
  logic [15:0] m_rx_hold = 16'h0000;

  typedef struct {
    logic [15:0] addr;
    logic        mw_en;
    logic [15:0] wdata;
    logic [15:0] ram_rd;
    logic [15:0] exp_rdata;
    logic        exp_we;
    logic [7:0]  exp_raddr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_stat();
    return {11'b0, m_rx_full, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0, 1'b0};
  endfunction

  // One clock: check handshake outputs at negedge, advance the model, return at posedge+1.
  task automatic step();
    logic pop, io_wr;
    @(negedge clk);
    chk("tx_valid", {15'b0, tx_valid}, {15'b0, exp_q.size() != 0});
    chk("rx_ready", {15'b0, rx_ready}, {15'b0, ~m_rx_full});
    pop = tx_ready && exp_q.size() != 0;
    if (pop) chk("tx_data", tx_data, exp_q[0]);
    if (reset) begin
      exp_q.delete();
      m_ovf = 1'b0; m_rx_full = 1'b0; m_rx_hold = 16'h0000; m_mw_q = 1'b0;
    end else begin
      io_wr = cpu_mw_en && !m_mw_q;
      if (pop) void'(exp_q.pop_front());
      if (io_wr && cpu_addr == TXD) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(cpu_wdata);
        else m_ovf = 1'b1;
      end
      if (io_wr && cpu_addr == STAT) m_ovf = 1'b0;
      if (rx_valid && !m_rx_full) begin
        m_rx_hold = rx_data; m_rx_full = 1'b1;
      end else if (io_wr && cpu_addr == RXD) begin
        m_rx_full = 1'b0;
      end
      m_mw_q = cpu_mw_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
    cpu_addr = addr;
    #1;
    chk(name, cpu_rdata, exp);
  endtask

  // Write with mw_en held for 'cycles' clocks, then one idle clock.
  task automatic wr(input logic [15:0] addr, input logic [15:0] data, input int cycles);
    cpu_addr = addr; cpu_wdata = data; cpu_mw_en = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    cpu_mw_en = 1'b0;
    step();
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
    step();
    tx_ready = 1'b0;
    chk("drained_tx_valid", {15'b0, tx_valid}, 16'h0000);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 1'b0, 16'h0000, 16'h1234, 16'h1234, 1'b0, 8'h10};
    vecs[1] = '{16'h00FF, 1'b1, 16'hA5A5, 16'hBEEF, 16'hBEEF, 1'b1, 8'hFF};
    vecs[2] = '{16'h0100, 1'b1, 16'h5A5A, 16'h5555, 16'h0000, 1'b0, 8'h00};
    vecs[3] = '{TXD,      1'b0, 16'h0000, 16'h1111, 16'h0000, 1'b0, 8'h00};
    vecs[4] = '{STAT,     1'b0, 16'h0000, 16'h2222, 16'h0002, 1'b0, 8'h01};
    vecs[5] = '{RXD,      1'b0, 16'h0000, 16'h3333, 16'h0000, 1'b0, 8'h02};
    vecs[6] = '{16'hFF03, 1'b1, 16'h9999, 16'h4444, 16'h0000, 1'b0, 8'h03};
    vecs[7] = '{16'hFE00, 1'b0, 16'h0000, 16'h7777, 16'h0000, 1'b0, 8'h00};
    vecs[8] = '{16'h0000, 1'b1, 16'h0001, 16'h4321, 16'h4321, 1'b1, 8'h00};

    reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h0000; cpu_mw_en = 1'b0;
    ram_rdata = 16'h0000; tx_ready = 1'b0; rx_data = 16'h0000; rx_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    rd("reset_stat", STAT, 16'h0002);
    chk("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("reset_rx_ready", {15'b0, rx_ready}, 16'h0001);

    // Decode table; unmapped writes inside it must leave no trace.
    for (int i = 0; i < 9; i++) begin
      cpu_addr = vecs[i].addr; cpu_mw_en = vecs[i].mw_en;
      cpu_wdata = vecs[i].wdata; ram_rdata = vecs[i].ram_rd;
      #1;
      chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_we", i), {15'b0, ram_we}, {15'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d_raddr", i), {8'b0, ram_addr}, {8'b0, vecs[i].exp_raddr});
      chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].wdata);
      step();
    end
    cpu_mw_en = 1'b0;
    step();
    rd("after_table_stat", STAT, 16'h0002);

    // Multi-cycle RAM write: ram_we every cycle, no FIFO push.
    cpu_addr = 16'h0010; cpu_wdata = 16'hA5A5; cpu_mw_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ram_we_hold", {15'b0, ram_we}, 16'h0001);
      chk("ram_addr_hold", {8'b0, ram_addr}, 16'h0010);
      step();
    end
    cpu_mw_en = 1'b0;
    step();
    ram_rdata = 16'h5A5A;
    rd("ram_read", 16'h0010, 16'h5A5A);
    rd("ram_write_no_push", STAT, 16'h0002);

    // Fill past full with 2-cycle pulses: one push each, fifth word overflows.
    tx_ready = 1'b0;
    wr(TXD, 16'h1111, 2); wr(TXD, 16'h2222, 2); wr(TXD, 16'h3333, 2); wr(TXD, 16'h4444, 2);
    rd("full_stat", STAT, 16'h0004);
    wr(TXD, 16'h5555, 2);
    rd("ovf_stat", STAT, 16'h000C);
    rd("ovf_stat_model", STAT, m_stat());
    drain();
    wr(STAT, 16'hFFFF, 1);
    rd("ovf_clear_stat", STAT, 16'h0002);

    // Push in the same cycle as a pop while full.
    wr(TXD, 16'h7001, 1); wr(TXD, 16'h7002, 1); wr(TXD, 16'h7003, 1); wr(TXD, 16'h7004, 1);
    cpu_addr = TXD; cpu_wdata = 16'h6666; cpu_mw_en = 1'b1; tx_ready = 1'b1;
    step();
    cpu_mw_en = 1'b0; tx_ready = 1'b0;
    step();
    rd("push_pop_full_stat", STAT, 16'h0004);
    drain();

    // Rx capture, hold-off while full, acknowledge, then the next capture.
    rx_data = 16'hBEEF; rx_valid = 1'b1;
    step();
    rx_data = 16'hCAFE;
    rd("rx_read1", RXD, 16'hBEEF);
    rd("rx_stat", STAT, 16'h0012);
    step(); step();
    rd("rx_held_off", RXD, 16'hBEEF);
    cpu_addr = RXD; cpu_mw_en = 1'b1;
    step();
    cpu_mw_en = 1'b0;
    rd("rx_ack_keeps_hold", RXD, 16'hBEEF);
    chk("rx_ready_after_ack", {15'b0, rx_ready}, 16'h0001);
    step();
    rx_valid = 1'b0;
    rd("rx_read2", RXD, 16'hCAFE);
    rd("rx_stat2", STAT, m_stat());

    // Reset with three queued words and rx_full set.
    wr(TXD, 16'h0A01, 1); wr(TXD, 16'h0A02, 1); wr(TXD, 16'h0A03, 1);
    rd("pre_reset_stat", STAT, 16'h0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("post_reset_rx_ready", {15'b0, rx_ready}, 16'h0001);
    rd("post_reset_stat", STAT, 16'h0002);
    rd("post_reset_rxd", RXD, 16'h0000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
